echo_indication_fifo: RTL and testbench
=======================================

// Module: echo_indication_fifo
//
// PURPOSE
// - Downstream consumer of the Echo indication$heard method. Buffers up to DEPTH
//   (meth, v) messages and serializes each onto a 32-bit word stream toward the
//   host transport: header word (meth) first, then payload word (v, last=1).
// - Decouples Echo's respond_rule from transport back-pressure, so Echo's
//   busy_delay clears as soon as a FIFO slot is free.
//
// PARAMETERS
// - DEPTH  4  message slots; power of two, >= 2
// - AW     2  pointer width; must equal log2(DEPTH)
//
// PORTS
// - CLK                  in   1   clock, rising edge
// - RST                  in   1   reset, asynchronous, active-high
// - heard__ENA           in   1   Echo indication$heard__ENA
// - heard$meth           in   32  message method id
// - heard$v              in   32  message value
// - heard__RDY           out  1   slot free; drives Echo indication$heard__RDY
// - out$enq__ENA         out  1   output word valid
// - out$enq$data         out  32  output word
// - out$enq$last         out  1   1 on the payload (second) word of a message
// - out$enq__RDY         in   1   transport can accept a word this cycle
// - stat$count           out  32  messages fully sent (ECHO_IND_STATS_EN only)
//
// BEHAVIOUR
// - Storage: DEPTH x 64-bit entries {meth, v}; rd_ptr/wr_ptr are AW bits and
//   wrap modulo DEPTH; occupancy count is AW+1 bits, range 0..DEPTH.
// - Push: heard__ENA & heard__RDY writes mem[wr_ptr] and advances wr_ptr.
//   heard__RDY = (count != DEPTH), computed from registered state only. No push
//   while full, even if a pop completes in the same cycle.
// - ENA without RDY: ignored; no state change.
// - Serializer: phase register, HDR(0) / PAY(1).
//   out$enq__ENA = (count != 0), independent of out$enq__RDY.
//   HDR: data = mem[rd_ptr].meth, last = 0. PAY: data = mem[rd_ptr].v, last = 1.
//   Transfer happens when out$enq__ENA & out$enq__RDY.
//   HDR transfer sets phase to PAY.
//   PAY transfer sets phase to HDR, advances rd_ptr, decrements count.
// - Data, last and phase hold stable while ENA=1 and RDY=0.
// - Latency: a message pushed into an empty FIFO presents its header on the
//   next cycle. No same-cycle bypass. Minimum 2 cycles per message out.
// - Simultaneous push + final (PAY) pop: count unchanged, both pointers advance.
// - Push during HDR->PAY transfer: count increments. A partially sent head
//   entry is never overwritten, because it still counts as occupied.
// - Reset (asserted at any time, including mid-message): ptrs=0, count=0,
//   phase=HDR, stat$count=0. Any buffered or half-sent messages are discarded.
//   Memory contents are not reset.
// - Reset values: heard__RDY=1, out$enq__ENA=0, out$enq$last=0, out$enq$data=0.
//
// CONFIGURATION
// - ECHO_IND_STATS_EN defined: a 32-bit stat$count register increments by 1 on
//   each PAY transfer, wraps 0xFFFFFFFF -> 0, and is cleared by RST.
//   The stat$count port exists.
// - ECHO_IND_STATS_EN undefined: the counter and the stat$count port are
//   absent. All other behaviour is identical.
//
// TESTING
// - Push (meth=1, v=0x55) into empty FIFO with RDY=1 -> cycle+1: ENA=1,
//   data=1, last=0; cycle+2: data=0x55, last=1; cycle+3: ENA=0.
// - Push 4 messages with RDY=0 -> heard__RDY=0 after the 4th push.
//   A 5th ENA is dropped; drain yields exactly 4 messages in order.
// - Full FIFO, final PAY pop and heard__ENA in the same cycle -> push refused
//   and count=3; the next cycle the push is accepted.
// - Toggle RDY every cycle over 3 messages -> output order is
//   meth0,v0,meth1,v1,meth2,v2; data held stable while RDY=0.
// - Assert RST after the HDR of message 0 -> ENA=0 and heard__RDY=1 at once;
//   after release the next push's header is output; message 0's v is never
//   sent.
// - ECHO_IND_STATS_EN: 6 messages sent -> stat$count=6; preload 0xFFFFFFFF,
//   send 1 message -> stat$count=0.

Source files
------------

// File: rtl/echo_indication_fifo.sv
// echo_indication_fifo: buffers Echo heard (meth, v) messages and serializes each as header then payload word.
// Optional ECHO_IND_STATS_EN adds the stat_count sent-message counter and port.
module echo_indication_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        heard__ENA,
    input  logic [31:0] heard_meth,
    input  logic [31:0] heard_v,
    output logic        heard__RDY,
    output logic        out_enq__ENA,
    output logic [31:0] out_enq_data,
    output logic        out_enq_last,
    input  logic        out_enq__RDY
`ifdef ECHO_IND_STATS_EN
    ,
    output logic [31:0] stat_count
`endif
);
    typedef enum logic {HDR = 1'b0, PAY = 1'b1} phase_t;
    phase_t        r_phase, w_phase_nxt;
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push, w_xfer, w_pop;
    logic [63:0]   w_head;
    assign heard__RDY   = r_cnt != (AW+1)'(DEPTH);
    assign out_enq__ENA = r_cnt != '0;
    assign w_push       = heard__ENA & heard__RDY;
    assign w_xfer       = out_enq__ENA & out_enq__RDY;
    assign w_pop        = w_xfer & (r_phase == PAY);
    assign w_head       = r_mem[r_rd];
    // Outputs are forced to zero while empty so unreset memory never leaks out.
    assign out_enq_data = !out_enq__ENA ? 32'd0 : (r_phase == PAY ? w_head[31:0] : w_head[63:32]);
    assign out_enq_last = out_enq__ENA & (r_phase == PAY);
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_xfer) w_phase_nxt = r_phase == HDR ? PAY : HDR;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_phase <= HDR;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= {heard_meth, heard_v};
    end
`ifdef ECHO_IND_STATS_EN
    logic [31:0] r_stat;
    assign stat_count = r_stat;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_stat <= '0;
        else if (w_pop) r_stat <= r_stat + 32'd1;
    end
`endif
endmodule

// File: tb/tb_echo_indication_fifo.sv
// tb_echo_indication_fifo: directed and random checks of echo_indication_fifo against a message-queue model.
module tb_echo_indication_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [31:0] meth = '0;
    logic [31:0] v = '0;
    logic        rdy_in = 1'b0;
    logic        h_rdy, o_ena, o_last;
    logic [31:0] o_data;
`ifdef ECHO_IND_STATS_EN
    logic [31:0] stat;
`endif
    int errors = 0;
    int checks = 0;
    typedef struct {logic [31:0] m; logic [31:0] v;} msg_t;
    msg_t q[$];
    bit   hdr_sent = 0;
    int   sent = 0;

    echo_indication_fifo dut (
        .CLK(clk), .RST(rst),
        .heard__ENA(ena), .heard_meth(meth), .heard_v(v), .heard__RDY(h_rdy),
        .out_enq__ENA(o_ena), .out_enq_data(o_data), .out_enq_last(o_last), .out_enq__RDY(rdy_in)
`ifdef ECHO_IND_STATS_EN
        , .stat_count(stat)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the model, then apply this cycle's inputs to the model and clock once.
    task automatic cyc();
        bit push_ok;
        chk("heard_rdy", 32'(h_rdy), 32'(q.size() != 4));
        chk("enq_ena", 32'(o_ena), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("enq_data", o_data, hdr_sent ? q[0].v : q[0].m);
            chk("enq_last", 32'(o_last), 32'(hdr_sent));
        end
`ifdef ECHO_IND_STATS_EN
        chk("stat_count", stat, 32'(sent));
`endif
        push_ok = ena && q.size() != 4;
        if (q.size() != 0 && rdy_in) begin
            if (hdr_sent) begin
                void'(q.pop_front());
                hdr_sent = 0;
                sent++;
            end else hdr_sent = 1;
        end
        if (push_ok) q.push_back('{meth, v});
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] m, input logic [31:0] d);
        ena = 1'b1; meth = m; v = d;
        cyc();
        ena = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_rdy", 32'(h_rdy), 32'd1);
        chk("reset_ena", 32'(o_ena), 32'd0);
        chk("reset_last", 32'(o_last), 32'd0);
        chk("reset_data", o_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // single message, latency and ordering
        rdy_in = 1'b1;
        push(32'd1, 32'h55);
        chk("lat_hdr", o_data, 32'd1);
        repeat (3) cyc();
        chk("lat_idle", 32'(o_ena), 32'd0);
        // fill with back-pressure, drop the fifth, drain
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h100 + i, 32'h200 + i);
        chk("full_rdy", 32'(h_rdy), 32'd0);
        push(32'hdead, 32'hbeef);
        rdy_in = 1'b1;
        repeat (9) cyc();
        chk("drain_empty", 32'(o_ena), 32'd0);
        // full FIFO: push refused in the cycle of the final pop, then accepted
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h300 + i, 32'h400 + i);
        rdy_in = 1'b1;
        cyc();
        ena = 1'b1; meth = 32'h777; v = 32'h888;
        cyc();
        chk("collide_rdy", 32'(h_rdy), 32'd1);
        cyc();
        ena = 1'b0;
        chk("collide_accept_rdy", 32'(h_rdy), 32'd0);
        repeat (10) cyc();
        // toggling back-pressure across three messages
        for (int i = 0; i < 3; i++) begin
            rdy_in = ~rdy_in;
            push(32'h500 + i, 32'h600 + i);
        end
        for (int i = 0; i < 14; i++) begin
            rdy_in = ~rdy_in;
            cyc();
        end
        rdy_in = 1'b1;
        repeat (2) cyc();
        chk("toggle_empty", 32'(o_ena), 32'd0);
        // asynchronous reset after message 0's header
        push(32'haaa, 32'hbbb);
        cyc();
        chk("mid_last", 32'(o_last), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_ena", 32'(o_ena), 32'd0);
        chk("async_rdy", 32'(h_rdy), 32'd1);
        chk("async_data", o_data, 32'd0);
        q.delete(); hdr_sent = 0; sent = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        push(32'hccc, 32'hddd);
        chk("post_reset_hdr", o_data, 32'hccc);
        repeat (3) cyc();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            ena = 1'($urandom_range(0, 1));
            rdy_in = ($urandom_range(0, 3) != 0);
            meth = $urandom; v = $urandom;
            cyc();
        end
        ena = 1'b0; rdy_in = 1'b1;
        repeat (10) cyc();
        chk("final_empty", 32'(o_ena), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
